// File: rtl/dmem_responder.sv
// Sized, sign-aware load/store responder over a word-organised data memory with fixed access latency.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned half/word accesses; otherwise their low address bits are forced to alignment.
module dmem_responder #(
  parameter int DEPTH   = 32,
  parameter int ADDR_W  = 7,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err
);

  // state    | meaning
  // S_IDLE   | waiting for a request
  // S_ACCESS | latency countdown; memory touched when the count reaches 0
  // S_RESP   | response held until the consumer takes it
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t              state, state_nx;
  logic [3:0]          cnt;
  logic                live;
  logic                c_we, c_uns;
  logic [ADDR_W-1:0]   c_addr;
  logic [1:0]          c_size;
  logic [31:0]         c_wdata;
  logic [31:0]         mem [DEPTH];

  logic [ADDR_W-1:0]   eff_addr;
  logic                access_err;
  logic [ADDR_W-3:0]   idx;
  logic [1:0]          lane;
  logic [31:0]         shifted, rd_ext, wrep, merged;
  logic [3:0]          be;
  logic                do_access;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (req_valid && req_ready) state_nx = S_ACCESS;
      S_ACCESS: if (cnt == 4'd0) state_nx = S_RESP;
      S_RESP:   if (resp_ready) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == S_IDLE) && live;
    resp_valid = (state == S_RESP);
  end

  always_comb begin
    eff_addr = c_addr;
`ifdef DMEM_MISALIGN_TRAP_EN
    access_err = (c_size == 2'b11) ||
                 (c_size == 2'b01 && c_addr[0]) ||
                 (c_size == 2'b10 && c_addr[1:0] != 2'b00);
`else
    access_err = (c_size == 2'b11);
    if (c_size == 2'b01) eff_addr[0] = 1'b0;
    if (c_size == 2'b10) eff_addr[1:0] = 2'b00;
`endif
  end

  assign idx       = eff_addr[ADDR_W-1:2];
  assign lane      = eff_addr[1:0];
  assign shifted   = mem[idx] >> {lane, 3'b000};
  assign do_access = (state == S_ACCESS) && (cnt == 4'd0);

  always_comb begin
    case (c_size)
      2'b00: begin
        rd_ext = c_uns ? {24'd0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
        be     = 4'b0001 << lane;
        wrep   = {4{c_wdata[7:0]}};
      end
      2'b01: begin
        rd_ext = c_uns ? {16'd0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
        be     = 4'b0011 << lane;
        wrep   = {2{c_wdata[15:0]}};
      end
      default: begin
        rd_ext = shifted;
        be     = 4'b1111;
        wrep   = c_wdata;
      end
    endcase
    for (int b = 0; b < 4; b++)
      merged[b*8 +: 8] = be[b] ? wrep[b*8 +: 8] : mem[idx][b*8 +: 8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      live       <= 1'b0;
      cnt        <= 4'd0;
      c_we       <= 1'b0;
      c_uns      <= 1'b0;
      c_addr     <= '0;
      c_size     <= 2'b00;
      c_wdata    <= 32'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      live <= 1'b1;
      case (state)
        S_IDLE: if (req_valid && req_ready) begin
          c_we    <= req_we;
          c_uns   <= req_unsigned;
          c_addr  <= req_addr;
          c_size  <= req_size;
          c_wdata <= req_wdata;
          cnt     <= 4'(LATENCY - 1);
        end
        S_ACCESS: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else begin
            resp_rdata <= (c_we || access_err) ? 32'd0 : rd_ext;
            resp_err   <= access_err;
          end
        end
        S_RESP: if (resp_ready) begin
          resp_rdata <= 32'd0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Array is cleared by reset so every word reads as zero after power-up.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'd0;
    end else if (do_access && c_we && !access_err) begin
      mem[idx] <= merged;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed test of dmem_responder against a byte-array reference model checked on every cycle.
module tb_dmem_responder;
  localparam int DEPTH = 32, ADDR_W = 7, LATENCY = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [1:0]        req_size = 2'b00;
  logic [31:0]       req_wdata = 32'd0;
  logic              resp_ready = 1'b1;
  logic              req_ready, resp_valid, resp_err;
  logic [31:0]       resp_rdata;

  int total = 0, bad = 0;

  dmem_responder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] mem_b [DEPTH*4];

  typedef struct { logic [31:0] rd; logic err; int due; } exp_t;
  exp_t q[$];
  int   cyc = 0;
  logic live_m = 1'b0, busy = 1'b0;

  function automatic void model(input logic we, input int addr, input logic [1:0] size,
                                input logic uns, input logic [31:0] wd,
                                output logic [31:0] rd, output logic err);
    int a, n;
    logic mis;
    longint v;
    a   = addr;
    err = (size == 2'b11);
    mis = (size == 2'b01 && (a % 2) != 0) || (size == 2'b10 && (a % 4) != 0);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (mis) err = 1'b1;
`else
    if (mis) a = (size == 2'b01) ? a - (a % 2) : a - (a % 4);
`endif
    n  = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
    rd = 32'd0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < n; i++) mem_b[a+i] = wd[i*8 +: 8];
    end else begin
      v = 0;
      for (int i = 0; i < n; i++) v += longint'(mem_b[a+i]) << (8*i);
      if (n < 4 && !uns && v >= (longint'(1) << (8*n-1))) v -= (longint'(1) << (8*n));
      rd = v[31:0];
    end
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) live_m <= 1'b0;
    else      live_m <= 1'b1;
  end
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    logic exp_v;
    if (!rst) begin
      chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      q.delete();
      busy = 1'b0;
      for (int i = 0; i < DEPTH*4; i++) mem_b[i] = 8'h00;
    end else begin
      chk("req_ready", {31'd0, req_ready}, {31'd0, !busy && live_m});
      exp_v = (q.size() > 0) && (cyc >= q[0].due);
      chk("resp_valid", {31'd0, resp_valid}, {31'd0, exp_v});
      if (resp_valid && q.size() > 0) begin
        chk("resp_rdata", resp_rdata, q[0].rd);
        chk("resp_err", {31'd0, resp_err}, {31'd0, q[0].err});
      end
      if (req_valid && req_ready) begin
        model(req_we, int'(req_addr), req_size, req_unsigned, req_wdata, e.rd, e.err);
        e.due = cyc + 1 + LATENCY;
        q.push_back(e);
        busy = 1'b1;
      end
      if (resp_valid && resp_ready && q.size() > 0) begin
        void'(q.pop_front());
        busy = 1'b0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic xact(input logic we, input logic [6:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wd,
                      output logic [31:0] rd, output logic err);
    int n;
    logic acc, got;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wd;
    n = 0; acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge clk); acc = req_ready;
      @(posedge clk); #1; n++;
    end
    req_valid = 1'b0;
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
    n = 0; got = 1'b0; rd = 32'hxxxxxxxx; err = 1'bx;
    while (acc && !got && n < 100) begin
      @(negedge clk);
      if (resp_valid && resp_ready) begin rd = resp_rdata; err = resp_err; got = 1'b1; end
      @(posedge clk); #1; n++;
    end
    if (acc && !got) chk("resp_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] rd, held;
    logic        er;
    int          n;
    logic        seen;

    repeat (2) @(negedge clk);
    chk("reset_req_ready", {31'd0, req_ready}, 32'd0);
    chk("reset_resp_rdata", resp_rdata, 32'd0);
    chk("reset_resp_err", {31'd0, resp_err}, 32'd0);
    @(posedge clk); #1; rst = 1'b1;

    xact(1, 7'h04, 2'b10, 0, 32'hDEADBEEF, rd, er);
    chk("sw_rdata", rd, 32'h0);
    chk("sw_err", {31'd0, er}, 32'd0);
    xact(0, 7'h04, 2'b10, 0, 32'h0, rd, er);
    chk("lw_04", rd, 32'hDEADBEEF);

    xact(1, 7'h08, 2'b10, 0, 32'h11223344, rd, er);
    xact(1, 7'h09, 2'b00, 0, 32'h000000F0, rd, er);
    xact(0, 7'h08, 2'b10, 0, 32'h0, rd, er);
    chk("lw_08_merged", rd, 32'h1122F044);
    xact(0, 7'h09, 2'b00, 0, 32'h0, rd, er);
    chk("lb_09", rd, 32'hFFFFFFF0);
    xact(0, 7'h09, 2'b00, 1, 32'h0, rd, er);
    chk("lbu_09", rd, 32'h000000F0);

    xact(1, 7'h0C, 2'b10, 0, 32'hCAFE1234, rd, er);
    xact(1, 7'h0E, 2'b01, 0, 32'h00008001, rd, er);
    xact(0, 7'h0E, 2'b01, 0, 32'h0, rd, er);
    chk("lh_0e", rd, 32'hFFFF8001);
    xact(0, 7'h0E, 2'b01, 1, 32'h0, rd, er);
    chk("lhu_0e", rd, 32'h00008001);
    xact(0, 7'h0C, 2'b01, 1, 32'h0, rd, er);
    chk("lhu_0c_kept", rd, 32'h00001234);
    xact(0, 7'h0C, 2'b10, 0, 32'h0, rd, er);
    chk("lw_0c", rd, 32'h80011234);

    xact(1, 7'h03, 2'b10, 0, 32'h12345678, rd, er);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("mis_sw_err", {31'd0, er}, 32'd1);
    xact(0, 7'h00, 2'b10, 0, 32'h0, rd, er);
    chk("lw_00_after_mis", rd, 32'h00000000);
    xact(0, 7'h0F, 2'b01, 1, 32'h0, rd, er);
    chk("mis_lh_err", {31'd0, er}, 32'd1);
    chk("mis_lh_rdata", rd, 32'h0);
`else
    chk("mis_sw_err", {31'd0, er}, 32'd0);
    xact(0, 7'h00, 2'b10, 0, 32'h0, rd, er);
    chk("lw_00_after_mis", rd, 32'h12345678);
    xact(0, 7'h0F, 2'b01, 1, 32'h0, rd, er);
    chk("mis_lh_err", {31'd0, er}, 32'd0);
    chk("mis_lh_rdata", rd, 32'h00008001);
`endif

    xact(1, 7'h14, 2'b11, 0, 32'h55555555, rd, er);
    chk("rsv_sw_err", {31'd0, er}, 32'd1);
    xact(0, 7'h14, 2'b11, 0, 32'h0, rd, er);
    chk("rsv_lw_err", {31'd0, er}, 32'd1);
    xact(0, 7'h14, 2'b10, 0, 32'h0, rd, er);
    chk("lw_14_untouched", rd, 32'h0);

    // back-pressure with a second request waiting
    @(posedge clk); #1;
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_addr = 7'h04; req_size = 2'b10; req_unsigned = 1'b0;
    @(negedge clk);
    chk("bp_first_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_addr = 7'h09; req_size = 2'b00; req_unsigned = 1'b1;
    n = 0; seen = 1'b0;
    while (!seen && n < 50) begin
      @(negedge clk); seen = resp_valid; n++;
    end
    if (!seen) chk("bp_valid_timeout", 32'd0, 32'd1);
    held = resp_rdata;
    chk("bp_held_value", held, 32'hDEADBEEF);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_rdata_stable", resp_rdata, 32'hDEADBEEF);
      chk("bp_req_ready_low", {31'd0, req_ready}, 32'd0);
      chk("bp_valid_held", {31'd0, resp_valid}, 32'd1);
    end
    @(posedge clk); #1; resp_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_before_hs", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("bp_ready_after_hs", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1; req_valid = 1'b0;
    n = 0; seen = 1'b0;
    while (!seen && n < 50) begin
      @(negedge clk);
      if (resp_valid) begin seen = 1'b1; rd = resp_rdata; end
      n++;
    end
    if (!seen) chk("bp_second_timeout", 32'd0, 32'd1);
    chk("bp_second_rdata", rd, 32'h000000F0);
    @(posedge clk); #1;

    // reset in the middle of a store
    req_valid = 1'b1; req_we = 1'b1; req_addr = 7'h10; req_size = 2'b10; req_wdata = 32'hAAAAAAAA;
    @(negedge clk);
    chk("mid_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1; rst = 1'b1;
    xact(0, 7'h10, 2'b10, 0, 32'h0, rd, er);
    chk("lw_10_after_abort", rd, 32'h0);
    xact(0, 7'h04, 2'b10, 0, 32'h0, rd, er);
    chk("lw_04_cleared", rd, 32'h0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the core's load/store path: accepts one byte/half/word load or store request at a time over a valid/ready handshake, performs it on an internal word-organised data memory after a fixed access latency, and returns read data or completion status over a second valid/ready handshake. It sits between the datapath's load/store issue logic and the data storage. It replaces the current zero-wait-state, word-only data memory, so that `lb`/`sw`-style accesses become multi-cycle, sized, sign-aware transactions.

## Interface
- `DEPTH`, 32: number of 32-bit words; power of two.
- `ADDR_W`, 7: byte-address width; equals log2(DEPTH)+2.
- `LATENCY`, 2: cycles spent in ACCESS; valid range 1-15.
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous assert, active-low (0 = reset).
- `req_valid` in 1: request present.
- `req_ready` out 1: responder can accept a request.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in ADDR_W: byte address.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_wdata` in 32: store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid` out 1: response present.
- `resp_ready` in 1: consumer accepts response.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `resp_err` out 1: request rejected; memory unchanged.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: `req_ready`=1. On `req_valid`&&`req_ready`, capture we/addr/size/unsigned/wdata, load counter with LATENCY-1, go to ACCESS. Inputs are ignored at all other times.
- ACCESS: `req_ready`=0. Counter decrements each cycle. At count 0, perform the access and go to RESP.
- RESP: `resp_valid`=1, with `resp_rdata` and `resp_err` held stable until `resp_valid`&&`resp_ready`, then go to IDLE.
- Word index is addr[ADDR_W-1:2]. Byte lane is addr[1:0].
- Alignment: a half access requires addr[0]=0. A word access requires addr[1:0]=00.
- Store: write only the addressed lane(s), via a byte-enable merge into the word. Other bytes stay unchanged.
- Load: extract the lane(s) and shift to bit 0. Bit 7 (byte) or bit 15 (half) extends to 32 bits unless `req_unsigned`. Word loads ignore `req_unsigned`.
- `req_size`=11 always sets `resp_err`=1, for both loads and stores.
- Misalignment handling is set by the macro in Configuration.
- Reset: state IDLE; `req_ready`=0 while `rst`=0 and 1 from the first cycle after release. `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, counter=0. All DEPTH words are cleared to 0.
- Reset asserted during ACCESS or RESP aborts the transaction. A store aborted in ACCESS before count 0 does not write.

## Timing
- Handshake is accepted at cycle T (edge where `req_valid`&&`req_ready`).
- Memory access occurs at edge T+LATENCY. `resp_valid` rises in cycle T+LATENCY.
- If `resp_ready`=1 on arrival, the response completes at edge T+LATENCY+1. `req_ready` is 1 again in the following cycle.
- Best-case throughput: one transaction per LATENCY+2 cycles.
- No combinational path from `req_valid` to `req_ready`, or from `resp_ready` to `resp_valid`. Both outputs are decoded from registered state.
- Back-pressure: `resp_ready` held low keeps the FSM in RESP indefinitely. `req_ready` stays 0 throughout.
- A load issued after a store's response completes observes the stored data. There is no read/write overlap.

## Configuration
- Macro `DMEM_MISALIGN_TRAP_EN`.
- Defined: a misaligned half or word access completes with `resp_err`=1 and `resp_rdata`=0. No write occurs.
- Undefined: the low address bits are forced to alignment (half clears addr[0], word clears addr[1:0]). The access proceeds normally, with `resp_err`=0.
- Reserved size (11) errors in both builds.

## Test plan
- Reset then word store: after `rst` release, store 0xDEADBEEF @0x04 size 10, then load @0x04 size 10. Response is `resp_rdata`=0xDEADBEEF, `resp_err`=0, and `resp_valid` rises exactly LATENCY cycles after each accept.
- Byte lanes and extension:
  - Store 0x000000F0 @0x09 size 00 over word 0x11223344 @0x08. Word becomes 0x1122F044.
  - Signed byte load @0x09 returns 0xFFFFFFF0.
  - Unsigned byte load @0x09 returns 0x000000F0.
- Half access: store 0x8001 @0x0E size 01.
  - Signed half load @0x0E returns 0xFFFF8001.
  - Unsigned half load @0x0E returns 0x00008001.
  - Bytes @0x0C-0x0D are unchanged.
- Misaligned word store @0x03 (0x12345678):
  - With `DMEM_MISALIGN_TRAP_EN`: `resp_err`=1 and word 0 is unchanged.
  - Without it: word 0 becomes 0x12345678, `resp_err`=0.
- Back-pressure: hold `resp_ready`=0 for 10 cycles after `resp_valid`. `resp_rdata`/`resp_err` stay stable, `req_ready` stays 0, and a second `req_valid` is not accepted until one cycle after the response handshake.
- Reset mid-transaction: assert `rst`=0 in ACCESS of a store 0xAAAAAAAA @0x10. `resp_valid`=0 immediately, and after release a load @0x10 returns 0x00000000.
